// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - ICache line refill over a single AXI4 INCR read burst
module icache_axi_refill #(
    parameter int         LINE_BEATS = 8,
    parameter logic [3:0] ARID       = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [31:0]              rd_addr,
    output logic                     ret_valid,
    output logic [LINE_BEATS*32-1:0] ret_data,
    output logic                     ret_err,
    output logic                     busy,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int          CW        = $clog2(LINE_BEATS);
    localparam logic [31:0] LINE_MASK = 32'(LINE_BEATS * 4 - 1);
    localparam logic [CW-1:0] LAST    = CW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            err;
    logic            beat_ok;
    logic            last_beat;

    assign arid    = ARID;
    assign arlen   = 8'(LINE_BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Beats carrying a foreign ID are drained (rready stays high) but otherwise ignored.
    assign beat_ok   = (state == S_R) && rvalid && (rid == ARID);
    assign last_beat = (cnt == LAST);

    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        ret_valid  = 1'b0;
        ret_err    = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rd_req) state_next = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_next = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (beat_ok && (last_beat || rlast)) state_next = S_DONE;
            end
            S_DONE: begin
                ret_valid  = 1'b1;
                ret_err    = err;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            araddr   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            ret_data <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && rd_req) begin
                araddr <= rd_addr & ~LINE_MASK;
                cnt    <= '0;
                err    <= 1'b0;
            end
            if (beat_ok) begin
                ret_data[32*cnt +: 32] <= rdata;
                cnt                    <= cnt + CW'(1);
                // Bus error, early rlast and missing rlast all poison the line.
                if (rresp[1] || (last_beat != rlast)) err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Memory-side slave of the icache_mem interface.
- Converts one ICache line-refill request into a single AXI4 INCR read burst of LINE_BEATS 32-bit beats.
- Assembles the beats into a 256-bit line and returns it to the ICache with a one-cycle ret_valid pulse.
- Sits between the ICache miss handler and the AXI read-address/read-data channels of the core bus bridge.

Parameters:
- LINE_BEATS, 8, number of 32-bit beats per line; fixed so that LINE_BEATS*32 = 256 = ret_data width.
- ARID, 4'h0, AXI ID driven on arid; only R beats with rid==ARID are accepted.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  refill request (icache_mem.rd_req); level, held by ICache until ret_valid.
- rd_addr  in  32  physical miss address (icache_mem.rd_addr).
- ret_valid  out  1  one-cycle pulse; ret_data is valid (icache_mem.ret_valid).
- ret_data  out  256  refilled line; beat k occupies bits [32k+31:32k] (icache_mem.ret_data).
- ret_err  out  1  qualifies ret_valid; line contains a bus error or protocol error.
- busy  out  1  high in any state other than IDLE.
- arid  out  4  constant ARID.
- araddr  out  32  line-aligned address.
- arlen  out  8  constant LINE_BEATS-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R ID.
- rdata  in  32  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset values: ret_valid=0, ret_err=0, ret_data=0, busy=0, arvalid=0, rready=0, araddr=0; FSM in IDLE; beat counter cnt=0.
- rst is synchronous and has priority in every state. Mid-burst reset returns to IDLE immediately; the interconnect is reset by the same rst.
- FSM states: IDLE, AR, R, DONE.
- IDLE:
  - When rd_req=1: latch araddr={rd_addr[31:5],5'b0}, clear cnt, clear the error flag, go to AR.
  - ret_data is not cleared; it holds the previous line.
- AR:
  - arvalid=1, held with araddr stable until arready=1 (AXI rule: no withdrawal).
  - On handshake go to R; arvalid drops the next cycle.
- R:
  - rready=1.
  - A beat is accepted when rvalid & rready & (rid==ARID). Beats with another rid are neither written nor counted.
  - On each accepted beat: ret_data[32*cnt +: 32] <= rdata and cnt++.
  - rresp[1]=1 (SLVERR/DECERR) sets the sticky error flag.
  - Terminate on the accepted beat where cnt==LINE_BEATS-1 or rlast=1, whichever comes first.
  - rlast without cnt==LINE_BEATS-1 (early last), or cnt==LINE_BEATS-1 without rlast, sets the error flag. In the missing-rlast case the FSM still terminates.
  - Then go to DONE.
- DONE:
  - ret_valid=1 and ret_err=error flag for exactly one cycle; next state is IDLE unconditionally.
  - rd_req is ignored in DONE and in IDLE's first cycle after DONE? No: the ICache deasserts rd_req in the cycle after ret_valid. Any rd_req seen in IDLE starts a new refill.
- rd_req and rd_addr are ignored outside IDLE; the address is latched once.
- busy=1 in AR, R and DONE.
- Minimum latency with arready and rvalid always 1 and rd_req asserted in cycle 0:
  - arvalid in cycle 1; beats accepted in cycles 2..9; ret_valid in cycle 10.
- ret_data holds its value after DONE until overwritten beat-by-beat by the next refill.
- Back-pressure: rready is held high in R. Stalls come only from rvalid gaps, which extend the R state without limit; no timeout.

Test Plan:
- Basic refill: rd_req=1, rd_addr=0x1C00_0014, arready=1, 8 beats rdata=0x1000_0000+k with rlast on k=7 -> araddr=0x1C00_0000, arlen=7, arsize=2, arburst=1; ret_valid only in cycle 10; ret_data[32k+:32]=0x1000_0000+k; ret_err=0.
- AR stall: arready low for 5 cycles -> arvalid and araddr stable throughout; handshake on cycle 6; ret_valid 5 cycles later than the basic case.
- R gaps and foreign ID: rvalid gaps of 1-3 cycles plus one beat with rid=4'h3 -> foreign beat ignored; line correct; ret_valid one cycle after the 8th accepted beat.
- Bus error: rresp=2'b10 on beat 3 -> all 8 beats stored; ret_valid with ret_err=1. The next clean refill returns ret_err=0.
- Protocol error: rlast on beat 5 -> terminate after beat 5; ret_valid with ret_err=1; beats 6-7 of ret_data keep their old values.
- Reset mid-burst: rst=1 after beat 4 -> next cycle arvalid=0, rready=0, busy=0, ret_valid=0, ret_data=0. A subsequent rd_req runs a normal refill.
